dram_cmd_sequencer: RTL and testbench

- Sits directly downstream of the request queue.
- Accepts one decoded memory request at a time over a valid/ready handshake and expands it into DDR command sequences (PRE/ACT/RD/WR), honouring bank timing.
- Keeps an open-row table per bank and issues periodic refresh.
- Commands are emitted at DRAM rate: at most one command every two clk cycles.

---
 rtl/dram_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_dram_cmd_sequencer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_sequencer.sv
// rtl/dram_cmd_sequencer.sv - expands memory requests into PRE/ACT/RD/WR/REF DDR commands with bank timing
// Optional macro CLOSED_PAGE_EN: precharge the bank after every column command (closed-page policy).
module dram_cmd_sequencer #(
    parameter int BG_WIDTH     = 2,
    parameter int BANK_WIDTH   = 2,
    parameter int ROW_WIDTH    = 15,
    parameter int COLUMN_WIDTH = 10,
    parameter int T_RP         = 24,
    parameter int T_RCD        = 24,
    parameter int T_CAS        = 24,
    parameter int T_BURST      = 4,
    parameter int T_CCD        = 8,
    parameter int T_REFI       = 7800,
    parameter int T_RFC        = 350
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [BG_WIDTH-1:0]     req_bg,
    input  logic [BANK_WIDTH-1:0]   req_bank,
    input  logic [ROW_WIDTH-1:0]    req_row,
    input  logic [COLUMN_WIDTH-1:0] req_col,
    output logic                    cmd_valid,
    output logic [2:0]              cmd_op,
    output logic [BG_WIDTH-1:0]     cmd_bg,
    output logic [BANK_WIDTH-1:0]   cmd_bank,
    output logic [ROW_WIDTH-1:0]    cmd_row,
    output logic [COLUMN_WIDTH-1:0] cmd_col,
    output logic                    refresh_active
);
    localparam int BW = BG_WIDTH + BANK_WIDTH;
    localparam int NB = 1 << BW;
    localparam int CW = 16;

    localparam logic [2:0] OP_RD = 3'd0, OP_WR = 3'd1, OP_ACT = 3'd2, OP_PRE = 3'd3, OP_REF = 3'd4;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DECIDE   = 3'd1;
    localparam logic [2:0] S_PRE      = 3'd2;
    localparam logic [2:0] S_ACT      = 3'd3;
    localparam logic [2:0] S_COL      = 3'd4;
    localparam logic [2:0] S_REF_PRE  = 3'd5;
    localparam logic [2:0] S_REF      = 3'd6;
    localparam logic [2:0] S_REF_WAIT = 3'd7;

    logic [2:0]              state;
    logic                    phase;
    logic                    started;
    logic [BW-1:0]           q_idx;
    logic                    q_write;
    logic [ROW_WIDTH-1:0]    q_row;
    logic [COLUMN_WIDTH-1:0] q_col;
    logic [NB-1:0]           open_vld;
    logic [ROW_WIDTH-1:0]    open_row [NB];
    logic [CW-1:0]           rtp_cnt  [NB];
    logic [CW-1:0]           trp_cnt, trcd_cnt, tccd_cnt, refi_cnt, rfc_cnt;
    logic                    refresh_pending;
    logic                    ref_hit;
    logic [BW-1:0]           ref_idx;

    assign refresh_pending = (refi_cnt == '0);
    // started keeps req_ready low while reset is held and on the first clock after release
    assign req_ready = started && (state == S_IDLE) && !refresh_pending;

    // Lowest-numbered open bank, for the refresh precharge sweep
    always_comb begin
        ref_hit = 1'b0;
        ref_idx = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (open_vld[i]) begin
                ref_hit = 1'b1;
                ref_idx = BW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            phase          <= 1'b0;
            started        <= 1'b0;
            q_idx          <= '0;
            q_write        <= 1'b0;
            q_row          <= '0;
            q_col          <= '0;
            open_vld       <= '0;
            trp_cnt        <= '0;
            trcd_cnt       <= '0;
            tccd_cnt       <= '0;
            rfc_cnt        <= '0;
            refi_cnt       <= CW'(T_REFI);
            refresh_active <= 1'b0;
            cmd_valid      <= 1'b0;
            cmd_op         <= '0;
            cmd_bg         <= '0;
            cmd_bank       <= '0;
            cmd_row        <= '0;
            cmd_col        <= '0;
            for (int i = 0; i < NB; i++) begin
                open_row[i] <= '0;
                rtp_cnt[i]  <= '0;
            end
        end else begin
            phase     <= ~phase;
            started   <= 1'b1;
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_bg    <= '0;
            cmd_bank  <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;

            // One DRAM slot per phase=1 clock; loads below override these decrements
            if (phase) begin
                if (trp_cnt  != '0) trp_cnt  <= trp_cnt  - CW'(1);
                if (trcd_cnt != '0) trcd_cnt <= trcd_cnt - CW'(1);
                if (tccd_cnt != '0) tccd_cnt <= tccd_cnt - CW'(1);
                if (refi_cnt != '0) refi_cnt <= refi_cnt - CW'(1);
                if (rfc_cnt  != '0) rfc_cnt  <= rfc_cnt  - CW'(1);
                for (int i = 0; i < NB; i++) begin
                    if (rtp_cnt[i] != '0) rtp_cnt[i] <= rtp_cnt[i] - CW'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (refresh_pending) begin
                        state <= S_REF_PRE;
                    end else if (req_valid && req_ready) begin
                        q_idx   <= {req_bg, req_bank};
                        q_write <= req_write;
                        q_row   <= req_row;
                        q_col   <= req_col;
                        state   <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
`ifdef CLOSED_PAGE_EN
                    state <= S_ACT;
`else
                    if (open_vld[q_idx] && open_row[q_idx] == q_row) state <= S_COL;
                    else if (open_vld[q_idx])                        state <= S_PRE;
                    else                                             state <= S_ACT;
`endif
                end
                S_PRE: begin
                    if (phase && rtp_cnt[q_idx] == '0) begin
                        cmd_valid       <= 1'b1;
                        cmd_op          <= OP_PRE;
                        cmd_bg          <= q_idx[BW-1:BANK_WIDTH];
                        cmd_bank        <= q_idx[BANK_WIDTH-1:0];
                        open_vld[q_idx] <= 1'b0;
                        trp_cnt         <= CW'(T_RP - 1);
`ifdef CLOSED_PAGE_EN
                        state           <= S_IDLE;
`else
                        state           <= S_ACT;
`endif
                    end
                end
                S_ACT: begin
                    if (phase && trp_cnt == '0) begin
                        cmd_valid       <= 1'b1;
                        cmd_op          <= OP_ACT;
                        cmd_bg          <= q_idx[BW-1:BANK_WIDTH];
                        cmd_bank        <= q_idx[BANK_WIDTH-1:0];
                        cmd_row         <= q_row;
                        open_vld[q_idx] <= 1'b1;
                        open_row[q_idx] <= q_row;
                        trcd_cnt        <= CW'(T_RCD - 1);
                        state           <= S_COL;
                    end
                end
                S_COL: begin
                    if (phase && trcd_cnt == '0 && tccd_cnt == '0) begin
                        cmd_valid      <= 1'b1;
                        cmd_op         <= q_write ? OP_WR : OP_RD;
                        cmd_bg         <= q_idx[BW-1:BANK_WIDTH];
                        cmd_bank       <= q_idx[BANK_WIDTH-1:0];
                        cmd_col        <= q_col;
                        tccd_cnt       <= CW'(T_CCD - 1);
                        rtp_cnt[q_idx] <= CW'(T_CAS + T_BURST - 1);
`ifdef CLOSED_PAGE_EN
                        state          <= S_PRE;
`else
                        state          <= S_IDLE;
`endif
                    end
                end
                S_REF_PRE: begin
                    if (!ref_hit) begin
                        state <= S_REF;
                    end else if (phase && rtp_cnt[ref_idx] == '0) begin
                        cmd_valid         <= 1'b1;
                        cmd_op            <= OP_PRE;
                        cmd_bg            <= ref_idx[BW-1:BANK_WIDTH];
                        cmd_bank          <= ref_idx[BANK_WIDTH-1:0];
                        open_vld[ref_idx] <= 1'b0;
                        trp_cnt           <= CW'(T_RP - 1);
                        refresh_active    <= 1'b1;
                    end
                end
                S_REF: begin
                    if (phase && trp_cnt == '0) begin
                        cmd_valid      <= 1'b1;
                        cmd_op         <= OP_REF;
                        refresh_active <= 1'b1;
                        rfc_cnt        <= CW'(T_RFC - 1);
                        state          <= S_REF_WAIT;
                    end
                end
                S_REF_WAIT: begin
                    if (phase && rfc_cnt == '0) begin
                        refresh_active <= 1'b0;
                        refi_cnt       <= CW'(T_REFI);
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// tb/tb_dram_cmd_sequencer.sv - scoreboard bench for dram_cmd_sequencer (T_REFI=200, T_RFC=50)
module tb_dram_cmd_sequencer;
    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  bg;
        logic [1:0]  bank;
        logic [14:0] row;
        logic [9:0]  col;
    } cmd_t;

    localparam logic [2:0] OP_RD = 3'd0, OP_WR = 3'd1, OP_ACT = 3'd2, OP_PRE = 3'd3, OP_REF = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_bg = '0;
    logic [1:0]  req_bank = '0;
    logic [14:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        req_ready;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [14:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        refresh_active;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_rd_t = 0;
    cmd_t obs_c[$];
    int   obs_t[$];
    cmd_t exp_c[$];
    logic ra_q = 1'b0;
    int   ra_rise = -1;
    int   ra_fall = -1;
    int   ready_in_ref = 0;

    dram_cmd_sequencer #(.T_REFI(200), .T_RFC(50)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_bg(req_bg), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .refresh_active(refresh_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && cmd_valid) begin
            obs_c.push_back({cmd_op, cmd_bg, cmd_bank, cmd_row, cmd_col});
            obs_t.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            ra_q <= 1'b0; ra_rise <= -1; ra_fall <= -1; ready_in_ref <= 0;
        end else begin
            if (refresh_active && !ra_q) ra_rise <= cyc;
            if (!refresh_active && ra_q) ra_fall <= cyc;
            if (refresh_active && req_ready) ready_in_ref <= ready_in_ref + 1;
            ra_q <= refresh_active;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    function automatic cmd_t mk(input logic [2:0] op, input logic [1:0] bg, input logic [1:0] bank,
                                input logic [14:0] row, input logic [9:0] col);
        return {op, bg, bank, row, col};
    endfunction

    function automatic string fmt(input cmd_t c);
        return $sformatf("op=%0d bg=%0d bank=%0d row=%0h col=%0h", c.op, c.bg, c.bank, c.row, c.col);
    endfunction

    function automatic cmd_t pop_obs(output int t);
        if (obs_c.size() == 0) begin
            t = -1;
            return '1;
        end
        t = obs_t.pop_front();
        return obs_c.pop_front();
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        obs_c.delete(); obs_t.delete(); exp_c.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_req(input logic wr, input logic [1:0] bg, input logic [1:0] bank,
                            input logic [14:0] row, input logic [9:0] col);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_bg = bg; req_bank = bank; req_row = row; req_col = col;
        n = 0;
        while (!req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL handshake_timeout got req_ready=0 after %0d cycles want 1", n);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_cmds(input int n, input int bound, input string name);
        int k = 0;
        while (obs_c.size() < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (obs_c.size() < n) begin
            failures++;
            $display("FAIL %s_timeout got %0d commands want %0d", name, obs_c.size(), n);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, cmd_valid, cmd_op, refresh_active} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b valid=%b op=%0d ref=%b want all 0",
                     req_ready, cmd_valid, cmd_op, refresh_active);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got ready=%b valid=%b want ready=1 valid=0", req_ready, cmd_valid);
        end
    endtask

    task automatic test_read_act();
        cmd_t o, e;
        int   t[2];
        int   n, ready_hi;
        apply_reset();
        exp_c.push_back(mk(OP_ACT, 2'd1, 2'd2, 15'h10, 10'd0));
        exp_c.push_back(mk(OP_RD, 2'd1, 2'd2, 15'd0, 10'd5));
        send_req(1'b0, 2'd1, 2'd2, 15'h10, 10'd5);
        n = 0; ready_hi = 0;
        while (!(cmd_valid && cmd_op == OP_RD) && n < 300) begin
            if (req_ready) ready_hi++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready_hi != 0 || n >= 300) begin
            failures++;
            $display("FAIL read_act_ready_low got ready_high_cycles=%0d wait=%0d want 0", ready_hi, n);
        end
        wait_cmds(2, 50, "read_act");
        for (int i = 0; i < 2; i++) begin
            o = pop_obs(t[i]);
            e = exp_c.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL read_act_cmd%0d got %s want %s", i, fmt(o), fmt(e));
            end
        end
        checks++;
        if (t[1] - t[0] != 48) begin
            failures++;
            $display("FAIL read_act_trcd got %0d clk want 48", t[1] - t[0]);
        end
        last_rd_t = t[1];
    endtask

    task automatic test_row_hit();
        cmd_t o, e;
        int   t;
        exp_c.push_back(mk(OP_RD, 2'd1, 2'd2, 15'd0, 10'd9));
        send_req(1'b0, 2'd1, 2'd2, 15'h10, 10'd9);
        wait_cmds(1, 100, "row_hit");
        o = pop_obs(t);
        e = exp_c.pop_front();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL row_hit_cmd got %s want %s", fmt(o), fmt(e));
        end
        checks++;
        if (t - last_rd_t < 16 || t - last_rd_t > 20) begin
            failures++;
            $display("FAIL row_hit_tccd got %0d clk want 16..20", t - last_rd_t);
        end
        last_rd_t = t;
    endtask

    task automatic test_row_miss();
        cmd_t o, e;
        int   t[3];
        exp_c.push_back(mk(OP_PRE, 2'd1, 2'd2, 15'd0, 10'd0));
        exp_c.push_back(mk(OP_ACT, 2'd1, 2'd2, 15'h20, 10'd0));
        exp_c.push_back(mk(OP_RD, 2'd1, 2'd2, 15'd0, 10'd3));
        send_req(1'b0, 2'd1, 2'd2, 15'h20, 10'd3);
        wait_cmds(3, 300, "row_miss");
        for (int i = 0; i < 3; i++) begin
            o = pop_obs(t[i]);
            e = exp_c.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL row_miss_cmd%0d got %s want %s", i, fmt(o), fmt(e));
            end
        end
        checks++;
        if (t[0] - last_rd_t < 56 || t[0] - last_rd_t > 60) begin
            failures++;
            $display("FAIL row_miss_rtp got %0d clk want 56..60", t[0] - last_rd_t);
        end
        checks++;
        if (t[1] - t[0] != 48 || t[2] - t[1] != 48) begin
            failures++;
            $display("FAIL row_miss_trp_trcd got act_gap=%0d rd_gap=%0d want 48 48", t[1] - t[0], t[2] - t[1]);
        end
        last_rd_t = t[2];
    endtask

    task automatic test_write();
        cmd_t o, e;
        int   t;
        exp_c.push_back(mk(OP_WR, 2'd1, 2'd2, 15'd0, 10'd7));
        send_req(1'b1, 2'd1, 2'd2, 15'h20, 10'd7);
        wait_cmds(1, 100, "write");
        o = pop_obs(t);
        e = exp_c.pop_front();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL write_cmd got %s want %s", fmt(o), fmt(e));
        end
        checks++;
        if (t - last_rd_t < 16 || t - last_rd_t > 20) begin
            failures++;
            $display("FAIL write_tccd got %0d clk want 16..20", t - last_rd_t);
        end
    endtask

    task automatic test_refresh();
        cmd_t o, e;
        int   t[7];
        int   k;
        apply_reset();
        exp_c.push_back(mk(OP_ACT, 2'd0, 2'd0, 15'd1, 10'd0));
        exp_c.push_back(mk(OP_RD, 2'd0, 2'd0, 15'd0, 10'd0));
        exp_c.push_back(mk(OP_ACT, 2'd3, 2'd1, 15'd2, 10'd0));
        exp_c.push_back(mk(OP_RD, 2'd3, 2'd1, 15'd0, 10'd1));
        send_req(1'b0, 2'd0, 2'd0, 15'd1, 10'd0);
        send_req(1'b0, 2'd3, 2'd1, 15'd2, 10'd1);
        exp_c.push_back(mk(OP_PRE, 2'd0, 2'd0, 15'd0, 10'd0));
        exp_c.push_back(mk(OP_PRE, 2'd3, 2'd1, 15'd0, 10'd0));
        exp_c.push_back(mk(OP_REF, 2'd0, 2'd0, 15'd0, 10'd0));
        wait_cmds(7, 900, "refresh");
        for (int i = 0; i < 7; i++) begin
            o = pop_obs(t[i]);
            e = exp_c.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL refresh_cmd%0d got %s want %s", i, fmt(o), fmt(e));
            end
        end
        checks++;
        if (t[5] - t[4] != 2 || t[6] - t[5] != 48) begin
            failures++;
            $display("FAIL refresh_spacing got pre_gap=%0d ref_gap=%0d want 2 48", t[5] - t[4], t[6] - t[5]);
        end
        k = 0;
        while (ra_fall < 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (ra_rise != t[4]) begin
            failures++;
            $display("FAIL refresh_active_rise got %0d want %0d", ra_rise, t[4]);
        end
        checks++;
        if (ra_fall != t[6] + 100) begin
            failures++;
            $display("FAIL refresh_active_fall got %0d want %0d", ra_fall, t[6] + 100);
        end
        checks++;
        if (ready_in_ref != 0) begin
            failures++;
            $display("FAIL refresh_ready_low got %0d ready cycles want 0", ready_in_ref);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL refresh_done_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_reset_mid();
        cmd_t o, e;
        int   t[5];
        apply_reset();
        exp_c.push_back(mk(OP_ACT, 2'd0, 2'd1, 15'd5, 10'd0));
        exp_c.push_back(mk(OP_RD, 2'd0, 2'd1, 15'd0, 10'd0));
        exp_c.push_back(mk(OP_ACT, 2'd1, 2'd2, 15'h10, 10'd0));
        exp_c.push_back(mk(OP_RD, 2'd1, 2'd2, 15'd0, 10'd0));
        exp_c.push_back(mk(OP_PRE, 2'd1, 2'd2, 15'd0, 10'd0));
        send_req(1'b0, 2'd0, 2'd1, 15'd5, 10'd0);
        send_req(1'b0, 2'd1, 2'd2, 15'h10, 10'd0);
        send_req(1'b0, 2'd1, 2'd2, 15'h30, 10'd0);
        wait_cmds(5, 300, "reset_mid_pre");
        for (int i = 0; i < 5; i++) begin
            o = pop_obs(t[i]);
            e = exp_c.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid_cmd%0d got %s want %s", i, fmt(o), fmt(e));
            end
        end
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b0 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_quiet got valid=%b ready=%b want 0 0", cmd_valid, req_ready);
            end
        end
        obs_c.delete(); obs_t.delete();
        rst_n = 1'b1;
        exp_c.push_back(mk(OP_ACT, 2'd0, 2'd1, 15'd5, 10'd0));
        exp_c.push_back(mk(OP_RD, 2'd0, 2'd1, 15'd0, 10'd2));
        send_req(1'b0, 2'd0, 2'd1, 15'd5, 10'd2);
        wait_cmds(2, 100, "reset_mid_after");
        for (int i = 0; i < 2; i++) begin
            o = pop_obs(t[i]);
            e = exp_c.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid_after_cmd%0d got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

`ifdef CLOSED_PAGE_EN
    task automatic test_closed_page();
        cmd_t o, e;
        int   t[6];
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            exp_c.push_back(mk(OP_ACT, 2'd2, 2'd3, 15'd7, 10'd0));
            exp_c.push_back(mk(OP_RD, 2'd2, 2'd3, 15'd0, 10'd1));
            exp_c.push_back(mk(OP_PRE, 2'd2, 2'd3, 15'd0, 10'd0));
        end
        send_req(1'b0, 2'd2, 2'd3, 15'd7, 10'd1);
        send_req(1'b0, 2'd2, 2'd3, 15'd7, 10'd1);
        wait_cmds(6, 400, "closed_page");
        for (int i = 0; i < 6; i++) begin
            o = pop_obs(t[i]);
            e = exp_c.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL closed_page_cmd%0d got %s want %s", i, fmt(o), fmt(e));
            end
        end
        checks++;
        if (t[2] - t[1] != 56 || t[5] - t[4] != 56 || t[3] - t[2] != 48) begin
            failures++;
            $display("FAIL closed_page_timing got pre1=%0d pre2=%0d act2=%0d want 56 56 48",
                     t[2] - t[1], t[5] - t[4], t[3] - t[2]);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef CLOSED_PAGE_EN
        test_closed_page();
`else
        test_read_act();
        test_row_hit();
        test_row_miss();
        test_write();
        test_refresh();
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
